// File: rtl/center_divider_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : center_divider_scheduler_if
// Description : Bundle between the centroid accumulators / path-decision logic
//               and center_divider_scheduler.
//               slave  : the divider scheduler (consumes frame and sums,
//                        produces centers and status).
//               master : the surrounding logic driving frame and sums.
//               Signals: video_frame_valid, mazeParametersDefined,
//               numer_flat {bottom,left,up,right}, denom_flat (same order),
//               bottom/left/upper/right_center, centers_valid, done, busy,
//               overrun.
// Revision    : 1.0 - initial release
// ============================================================================
interface center_divider_scheduler_if #(
    parameter int NUM_W = 10,
    parameter int DEN_W = 5
);
    logic                 video_frame_valid;
    logic                 mazeParametersDefined;
    logic [4*NUM_W-1:0]   numer_flat;
    logic [4*DEN_W-1:0]   denom_flat;
    logic [NUM_W-1:0]     bottom_center;
    logic [NUM_W-1:0]     left_center;
    logic [NUM_W-1:0]     upper_center;
    logic [NUM_W-1:0]     right_center;
    logic                 centers_valid;
    logic                 done;
    logic                 busy;
    logic                 overrun;

    modport slave (
        input  video_frame_valid, mazeParametersDefined, numer_flat, denom_flat,
        output bottom_center, left_center, upper_center, right_center,
        output centers_valid, done, busy, overrun
    );

    modport master (
        output video_frame_valid, mazeParametersDefined, numer_flat, denom_flat,
        input  bottom_center, left_center, upper_center, right_center,
        input  centers_valid, done, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/center_divider_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : center_divider_scheduler
// Description : Shares one serial restoring divider across the four centroid
//               channels (bottom, left, up, right). A qualified frame end
//               snapshots the four sum/count pairs, divides them in turn
//               (NUM_W+2 cycles each) and publishes all four centers at once
//               with a one-cycle done pulse.
// Ports       : clk  - system clock (posedge)
//               rst  - asynchronous active-high reset
//               bus  - center_divider_scheduler_if.slave (frame/sum inputs,
//                      center outputs, centers_valid/done/busy/overrun)
// Revision    : 1.0 - initial release
// ============================================================================
module center_divider_scheduler #(
    parameter int NUM_W = 10,   // must match the interface instance
    parameter int DEN_W = 5
) (
    input  wire logic clk,
    input  wire logic rst,
    center_divider_scheduler_if.slave bus
);
    localparam int CNT_W = $clog2(NUM_W + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DIV   = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_fv_d;
    logic [1:0]         r_ch;
    logic [NUM_W-1:0]   r_numer_snap [4];
    logic [DEN_W-1:0]   r_denom_snap [4];
    logic [NUM_W-1:0]   r_shadow     [4];
    logic [NUM_W-1:0]   r_center     [4];
    logic [DEN_W:0]     r_rem;
    logic [NUM_W-1:0]   r_quo;
    logic [CNT_W-1:0]   r_bitcnt;
    logic               r_valid;
    logic               r_done;
    logic               r_busy;
    logic               r_overrun;

    logic [NUM_W-1:0]   w_numer [4];
    logic [DEN_W-1:0]   w_denom [4];
    logic               w_fe;
    logic               w_start_req;
    logic [DEN_W:0]     w_t;
    logic [DEN_W:0]     w_den;
    logic               w_ge;
    logic [DEN_W:0]     w_diff;

    // Channel 0 (bottom) lives in the most significant slice.
    for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
        assign w_numer[gi] = bus.numer_flat[(3-gi)*NUM_W +: NUM_W];
        assign w_denom[gi] = bus.denom_flat[(3-gi)*DEN_W +: DEN_W];
    end

    assign w_fe        = r_fv_d & ~bus.video_frame_valid;
    assign w_start_req = w_fe & bus.mazeParametersDefined;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // With a zero divisor the subtraction always "fits", giving all ones.
    assign w_t    = {r_rem[DEN_W-1:0], r_quo[NUM_W-1]};
    assign w_den  = {1'b0, r_denom_snap[r_ch]};
    assign w_ge   = (w_t >= w_den);
    assign w_diff = w_t - w_den;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_fv_d    <= 1'b0;
            r_ch      <= 2'd0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_bitcnt  <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_numer_snap[i] <= '0;
                r_denom_snap[i] <= '0;
                r_shadow[i]     <= '0;
                r_center[i]     <= '0;
            end
        end else begin
            r_fv_d    <= bus.video_frame_valid;
            r_done    <= 1'b0;
            // Any qualified frame end outside IDLE (DONE included) is dropped.
            r_overrun <= w_start_req && (r_state != S_IDLE);

            case (r_state)
                S_IDLE: begin
                    if (w_start_req) begin
                        for (int i = 0; i < 4; i++) begin
                            r_numer_snap[i] <= w_numer[i];
                            r_denom_snap[i] <= w_denom[i];
                        end
                        r_ch    <= 2'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_rem    <= '0;
                    r_quo    <= r_numer_snap[r_ch];
                    r_bitcnt <= CNT_W'(NUM_W);
                    r_state  <= S_DIV;
                end
                S_DIV: begin
                    r_quo    <= {r_quo[NUM_W-2:0], w_ge};
                    r_rem    <= w_ge ? w_diff : w_t;
                    r_bitcnt <= r_bitcnt - 1'b1;
                    if (r_bitcnt == CNT_W'(1)) begin
                        r_state <= S_STORE;
                    end
                end
                S_STORE: begin
                    r_shadow[r_ch] <= r_quo;
                    if (r_ch == 2'd3) begin
                        // Publish here so the new set is visible during DONE,
                        // in the same cycle as the done pulse.
                        r_center[0] <= r_shadow[0];
                        r_center[1] <= r_shadow[1];
                        r_center[2] <= r_shadow[2];
                        r_center[3] <= r_quo;
                        r_done      <= 1'b1;
                        r_valid     <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_ch    <= r_ch + 2'd1;
                        r_state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.bottom_center = r_center[0];
    assign bus.left_center   = r_center[1];
    assign bus.upper_center  = r_center[2];
    assign bus.right_center  = r_center[3];
    assign bus.centers_valid = r_valid;
    assign bus.done          = r_done;
    assign bus.busy          = r_busy;
    assign bus.overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_center_divider_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_center_divider_scheduler
// Description : Self-checking bench for center_divider_scheduler. A cycle
//               model (countdown of a 48-cycle job, floor-division results)
//               is compared against the DUT every cycle; directed scenarios
//               add literal checks on values and timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_center_divider_scheduler;
    localparam int NUM_W = 10;
    localparam int DEN_W = 5;
    localparam int LAT   = 4 * (NUM_W + 2);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    center_divider_scheduler_if #(.NUM_W(NUM_W), .DEN_W(DEN_W)) bus ();

    center_divider_scheduler #(.NUM_W(NUM_W), .DEN_W(DEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   cyc = 0;
    int   m_cnt = 0;      // cycles of busy left; 0 = idle
    logic m_fvd = 1'b0;
    int   m_q   [4];
    int   m_ctr [4];
    logic m_done = 1'b0, m_ovr = 1'b0, m_valid = 1'b0;
    int   start_cyc = 0;
    int   dut_dones = 0;
    int   dut_ovrs  = 0;

    function automatic int expected_quotient(input int n, input int d);
        return (d == 0) ? (1 << NUM_W) - 1 : n / d;
    endfunction

    always @(posedge clk) begin
        logic fe;
        cyc++;
        if (rst) begin
            m_cnt = 0; m_fvd = 1'b0; m_done = 1'b0; m_ovr = 1'b0; m_valid = 1'b0;
            for (int i = 0; i < 4; i++) m_ctr[i] = 0;
        end else begin
            fe     = m_fvd & ~bus.video_frame_valid;
            m_done = 1'b0;
            m_ovr  = 1'b0;
            if (m_cnt > 0) begin
                if (fe && bus.mazeParametersDefined) m_ovr = 1'b1;
                m_cnt--;
                if (m_cnt == 1) begin
                    m_done  = 1'b1;
                    m_valid = 1'b1;
                    for (int i = 0; i < 4; i++) m_ctr[i] = m_q[i];
                end
            end else if (fe && bus.mazeParametersDefined) begin
                for (int i = 0; i < 4; i++)
                    m_q[i] = expected_quotient(int'(bus.numer_flat[(3-i)*NUM_W +: NUM_W]),
                                               int'(bus.denom_flat[(3-i)*DEN_W +: DEN_W]));
                m_cnt     = LAT + 1;
                start_cyc = cyc;
            end
            m_fvd = bus.video_frame_valid;
        end
        #1;
        if (bus.done)    dut_dones++;
        if (bus.overrun) dut_ovrs++;
        chk("done",    int'(bus.done),          int'(m_done));
        chk("busy",    int'(bus.busy),          int'(m_cnt > 0));
        chk("overrun", int'(bus.overrun),       int'(m_ovr));
        chk("valid",   int'(bus.centers_valid), int'(m_valid));
        chk("bottom",  int'(bus.bottom_center), m_ctr[0]);
        chk("left",    int'(bus.left_center),   m_ctr[1]);
        chk("upper",   int'(bus.upper_center),  m_ctr[2]);
        chk("right",   int'(bus.right_center),  m_ctr[3]);
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_inputs(input int n0, n1, n2, n3, input int d0, d1, d2, d3);
        bus.numer_flat = {NUM_W'(n0), NUM_W'(n1), NUM_W'(n2), NUM_W'(n3)};
        bus.denom_flat = {DEN_W'(d0), DEN_W'(d1), DEN_W'(d2), DEN_W'(d3)};
    endtask

    // Drop frame valid for one cycle; the posedge in between is the fe edge.
    task automatic frame_end();
        @(negedge clk) bus.video_frame_valid = 1'b0;
        @(negedge clk) bus.video_frame_valid = 1'b1;
    endtask

    task automatic wait_done(input string nm, input int bound, output int at_cyc);
        bit found = 0;
        at_cyc = -1;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (bus.done) begin found = 1; at_cyc = cyc; break; end
        end
        chk({nm, "_done_seen"}, int'(found), 1);
    endtask

    task automatic chk_centers(input string nm, input int b, l, u, r);
        chk({nm, "_bottom"}, int'(bus.bottom_center), b);
        chk({nm, "_left"},   int'(bus.left_center),   l);
        chk({nm, "_upper"},  int'(bus.upper_center),  u);
        chk({nm, "_right"},  int'(bus.right_center),  r);
    endtask

    initial begin
        int dc;
        int base_dones;
        int base_ovrs;
        bus.video_frame_valid     = 1'b0;
        bus.mazeParametersDefined = 1'b1;
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_busy",  int'(bus.busy), 0);
        chk("rst_valid", int'(bus.centers_valid), 0);
        chk_centers("rst", 0, 0, 0, 0);
        rst = 1'b0;
        bus.video_frame_valid = 1'b1;
        repeat (2) @(negedge clk);

        // Basic division; inputs disturbed right after the snapshot.
        set_inputs(15, 8, 115, 1023, 1, 1, 5, 31);
        frame_end();
        set_inputs(1, 2, 3, 4, 7, 7, 7, 7);
        wait_done("t1", 100, dc);
        chk("t1_latency", dc - start_cyc, 48);
        chk_centers("t1", 15, 8, 23, 33);
        chk("t1_valid", int'(bus.centers_valid), 1);
        repeat (3) @(negedge clk);

        // Divide by zero on every channel.
        set_inputs(100, 100, 100, 100, 0, 0, 0, 0);
        frame_end();
        wait_done("t2", 100, dc);
        chk("t2_latency", dc - start_cyc, 48);
        chk_centers("t2", 1023, 1023, 1023, 1023);
        repeat (3) @(negedge clk);

        // Second frame end 20 cycles into a job.
        base_dones = dut_dones;
        set_inputs(600, 90, 31, 7, 6, 9, 31, 3);
        frame_end();
        set_inputs(1, 1, 1, 1, 1, 1, 1, 1);
        repeat (18) @(negedge clk);
        frame_end();
        chk("t3_overrun", int'(bus.overrun), 1);
        chk_centers("t3_hold", 1023, 1023, 1023, 1023);
        wait_done("t3", 100, dc);
        chk_centers("t3", 100, 10, 1, 2);
        repeat (60) @(negedge clk);
        chk("t3_one_done", dut_dones - base_dones, 1);

        // Frame end landing in the DONE cycle.
        set_inputs(500, 400, 300, 200, 2, 4, 6, 8);
        frame_end();
        wait_done("t7", 100, dc);
        bus.video_frame_valid = 1'b0;
        @(negedge clk) bus.video_frame_valid = 1'b1;
        chk("t7_overrun", int'(bus.overrun), 1);
        chk("t7_busy",    int'(bus.busy), 0);
        chk_centers("t7", 250, 100, 50, 25);
        repeat (3) @(negedge clk);

        // Reset while channel 2 is dividing.
        set_inputs(1000, 999, 998, 997, 3, 3, 3, 3);
        frame_end();
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_busy",  int'(bus.busy), 0);
        chk("t4_valid", int'(bus.centers_valid), 0);
        chk_centers("t4_rst", 0, 0, 0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        set_inputs(77, 64, 1, 0, 7, 16, 1, 1);
        frame_end();
        wait_done("t4", 100, dc);
        chk("t4_latency", dc - start_cyc, 48);
        chk_centers("t4", 11, 4, 1, 0);
        repeat (3) @(negedge clk);

        // Frame end with parameters undefined.
        base_dones = dut_dones;
        base_ovrs  = dut_ovrs;
        bus.mazeParametersDefined = 1'b0;
        frame_end();
        chk("t5_busy", int'(bus.busy), 0);
        repeat (60) @(negedge clk);
        chk("t5_no_done", dut_dones - base_dones, 0);
        chk("t5_no_ovr",  dut_ovrs - base_ovrs, 0);
        chk_centers("t5", 11, 4, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
